// File: rtl/multiport_memory.sv
// Shared word array with NUM_PORTS independent request/ready ports, per-port wait states and byte-lane writes.
// Optional out-of-range error response is built when MULTIPORT_MEMORY_BOUNDS_CHECK_EN is defined.

module multiport_memory_port #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] wr,
    output logic                    commit,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_din,
    output logic [DATA_WIDTH/8-1:0] req_wr,
    output logic                    ready
);
    typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_addr <= '0;
            req_din  <= '0;
            req_wr   <= '0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        req_addr <= addr;
                        req_din  <= din;
                        req_wr   <= wr;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_STATES);
                        end else begin
                            state <= COMMIT;
                        end
                    end
                end
                WAIT: begin
                    // Dropping enable mid-wait abandons the access without a response.
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state <= COMMIT;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                COMMIT: begin
                    state <= RESP;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign commit = (state == COMMIT);
endmodule

module multiport_memory #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_din,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] port_wr,
    input  logic [NUM_PORTS-1:0]                port_enable,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     port_dout,
    output logic [NUM_PORTS-1:0]                port_ready,
    output logic [NUM_PORTS-1:0]                port_error
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] din_v;
    logic [NUM_PORTS-1:0][BYTES-1:0]      wr_v;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_din;
    logic [NUM_PORTS-1:0][BYTES-1:0]      req_wr;
    logic [NUM_PORTS-1:0][IDX_W-1:0]      idx;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout_q;
    logic [NUM_PORTS-1:0]                 commit;
    logic [NUM_PORTS-1:0]                 in_range;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign addr_v    = port_addr;
    assign din_v     = port_din;
    assign wr_v      = port_wr;
    assign port_dout = dout_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        multiport_memory_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .WAIT_STATES(WAIT_STATES)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .enable  (port_enable[p]),
            .addr    (addr_v[p]),
            .din     (din_v[p]),
            .wr      (wr_v[p]),
            .commit  (commit[p]),
            .req_addr(req_addr[p]),
            .req_din (req_din[p]),
            .req_wr  (req_wr[p]),
            .ready   (port_ready[p])
        );
        assign in_range[p] = ({1'b0, req_addr[p]} < DEPTH_LIM);
        assign idx[p]      = req_addr[p][IDX_W-1:0];
    end

    // Later ports overwrite earlier ones in loop order, so the highest index wins each lane.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (commit[p] && in_range[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (req_wr[p][b]) mem[idx[p]][b*8 +: 8] <= req_din[p][b*8 +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's writes land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (commit[p]) dout_q[p] <= in_range[p] ? mem[idx[p]] : '0;
            end
        end
    end

`ifdef MULTIPORT_MEMORY_BOUNDS_CHECK_EN
    logic [NUM_PORTS-1:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) err_q[p] <= commit[p] && !in_range[p];
        end
    end

    assign port_error = err_q;
`else
    assign port_error = '0;
`endif
endmodule

// File: tb/tb_multiport_memory.sv
// Directed bench for multiport_memory: three instances cover WAIT_STATES 0, 3 and 4.
// Instance 0 uses MEM_DEPTH=3000 to exercise the out-of-range path.

module tb_multiport_memory;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] addr [3];
    logic [63:0] din  [3];
    logic [7:0]  wr   [3];
    logic [1:0]  en   [3];
    logic [63:0] dout [3];
    logic [1:0]  rdy  [3];
    logic [1:0]  err  [3];

    int vectors = 0;
    int miscompares = 0;

`ifdef MULTIPORT_MEMORY_BOUNDS_CHECK_EN
    localparam logic OOR_ERR = 1'b1;
`else
    localparam logic OOR_ERR = 1'b0;
`endif

    multiport_memory #(.NUM_PORTS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(3000), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .port_addr(addr[0]), .port_din(din[0]), .port_wr(wr[0]),
        .port_enable(en[0]), .port_dout(dout[0]), .port_ready(rdy[0]), .port_error(err[0]));
    multiport_memory #(.NUM_PORTS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(4096), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .port_addr(addr[1]), .port_din(din[1]), .port_wr(wr[1]),
        .port_enable(en[1]), .port_dout(dout[1]), .port_ready(rdy[1]), .port_error(err[1]));
    multiport_memory #(.NUM_PORTS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(4096), .WAIT_STATES(4)) u4 (
        .clk(clk), .rst(rst), .port_addr(addr[2]), .port_din(din[2]), .port_wr(wr[2]),
        .port_enable(en[2]), .port_dout(dout[2]), .port_ready(rdy[2]), .port_error(err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on instance i, port p. Returns latency in cycles, response values and the cycle after.
    task automatic access(input int i, input int p, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] w, input bit scramble,
                          output int lat, output logic [31:0] dq, output logic er,
                          output logic rn, output logic en2, output logic [31:0] dn);
        @(negedge clk);
        addr[i][p*12 +: 12] = a;
        din[i][p*32 +: 32]  = d;
        wr[i][p*4 +: 4]     = w;
        en[i][p]            = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 1) begin
                addr[i][p*12 +: 12] = ~a;
                din[i][p*32 +: 32]  = ~d;
                wr[i][p*4 +: 4]     = 4'hF;
            end
        end while (!rdy[i][p] && lat < 40);
        dq = dout[i][p*32 +: 32];
        er = err[i][p];
        en[i][p] = 1'b0;
        wr[i][p*4 +: 4] = 4'h0;
        @(negedge clk);
        rn  = rdy[i][p];
        en2 = err[i][p];
        dn  = dout[i][p*32 +: 32];
    endtask

    // Both ports of instance i launched on the same edge.
    task automatic pair(input int i, input logic [11:0] a, input logic [31:0] d0, input logic [3:0] w0,
                        input logic [31:0] d1, input logic [3:0] w1,
                        output int lat, output logic r1, output logic [31:0] q0, output logic [31:0] q1);
        @(negedge clk);
        addr[i] = {a, a};
        din[i]  = {d1, d0};
        wr[i]   = {w1, w0};
        en[i]   = 2'b11;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy[i][0] && lat < 40);
        r1 = rdy[i][1];
        q0 = dout[i][31:0];
        q1 = dout[i][63:32];
        en[i] = 2'b00;
        wr[i] = 8'h00;
        @(negedge clk);
    endtask

    int          lat;
    logic [31:0] dq, dn, q0, q1;
    logic        er, rn, en2, r1, seen;

    initial begin
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; din[k] = '0; wr[k] = '0; en[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_dout%0d", k), dout[k][31:0] | dout[k][63:32], 32'h0);
            chk($sformatf("reset_ready%0d", k), {30'h0, rdy[k]}, 32'h0);
            chk($sformatf("reset_error%0d", k), {30'h0, err[k]}, 32'h0);
        end
        rst = 1'b0;

        // WAIT_STATES=0 write then read-back
        access(0, 0, 12'h010, 32'hDEADBEEF, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        chk("ws0_write_lat", lat, 2);
        chk("ws0_write_pulse", {31'h0, rn}, 32'h0);
        chk("ws0_write_err", {31'h0, er}, 32'h0);
        access(0, 0, 12'h010, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("ws0_read_lat", lat, 2);
        chk("ws0_read_data", dq, 32'hDEADBEEF);
        chk("ws0_dout_hold", dn, 32'hDEADBEEF);

        // Request captured on accept; later input changes ignored
        access(0, 1, 12'h061, 32'h00000002, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        access(0, 0, 12'h060, 32'h00000001, 4'hF, 1'b1, lat, dq, er, rn, en2, dn);
        access(0, 1, 12'h060, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("capture_data", dq, 32'h00000001);
        access(0, 1, 12'h061, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("capture_other_word", dq, 32'h00000002);

        // Same-edge byte-lane merge
        access(0, 0, 12'h030, 32'h0, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        pair(0, 12'h030, 32'hAAAAAAAA, 4'b0011, 32'h55555555, 4'b0110, lat, r1, q0, q1);
        chk("merge_lat", lat, 2);
        chk("merge_ready1", {31'h0, r1}, 32'h1);
        access(0, 0, 12'h030, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("merge_word", dq, 32'h005555AA);

        // Same-edge read and write: read sees old contents
        access(0, 1, 12'h040, 32'h11111111, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        pair(0, 12'h040, 32'h0, 4'h0, 32'hCAFEF00D, 4'hF, lat, r1, q0, q1);
        chk("rw_read_old", q0, 32'h11111111);
        chk("rw_write_preword", q1, 32'h11111111);
        access(0, 0, 12'h040, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("rw_read_new", dq, 32'hCAFEF00D);

        // WAIT_STATES=3
        access(1, 0, 12'h020, 32'h12345678, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        chk("ws3_write_lat", lat, 5);
        access(1, 1, 12'h020, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("ws3_read_lat", lat, 5);
        chk("ws3_read_data", dq, 32'h12345678);
        chk("ws3_ready_width", {31'h0, rn}, 32'h0);

        // WAIT_STATES=4 abort during WAIT
        access(2, 0, 12'h050, 32'h0, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        chk("ws4_write_lat", lat, 6);
        @(negedge clk);
        addr[2][11:0] = 12'h050; din[2][31:0] = 32'hFFFFFFFF; wr[2][3:0] = 4'hF; en[2][0] = 1'b1;
        repeat (2) @(negedge clk);
        en[2][0] = 1'b0; wr[2][3:0] = 4'h0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = seen | rdy[2][0];
        end
        chk("abort_no_ready", {31'h0, seen}, 32'h0);
        access(2, 0, 12'h050, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("abort_no_write", dq, 32'h0);

        // Reset during WAIT
        access(2, 0, 12'h070, 32'hA5A5A5A5, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        access(2, 0, 12'h070, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("pre_reset_dout", dq, 32'hA5A5A5A5);
        @(negedge clk);
        addr[2][11:0] = 12'h070; din[2][31:0] = 32'h0; wr[2][3:0] = 4'hF; en[2][0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_dout", dout[2][31:0], 32'h0);
        chk("midreset_ready", {30'h0, rdy[2]}, 32'h0);
        chk("midreset_error", {30'h0, err[2]}, 32'h0);
        @(negedge clk);
        rst = 1'b0; en[2][0] = 1'b0; wr[2][3:0] = 4'h0;
        access(2, 0, 12'h070, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("reset_no_write", dq, 32'hA5A5A5A5);

        // Depth boundary on instance 0 (MEM_DEPTH=3000)
        access(0, 0, 12'h400, 32'h0BADCAFE, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        access(0, 0, 12'hBB7, 32'h76543210, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        chk("last_word_err", {31'h0, er}, 32'h0);
        access(0, 1, 12'hBB7, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("last_word_data", dq, 32'h76543210);
        access(0, 1, 12'hC00, 32'h12345678, 4'hF, 1'b0, lat, dq, er, rn, en2, dn);
        chk("oor_write_lat", lat, 2);
        chk("oor_write_err", {31'h0, er}, {31'h0, OOR_ERR});
        chk("oor_write_dout", dq, 32'h0);
        chk("oor_err_width", {31'h0, en2}, 32'h0);
        access(0, 1, 12'hC00, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("oor_read_dout", dq, 32'h0);
        chk("oor_read_err", {31'h0, er}, {31'h0, OOR_ERR});
        access(0, 0, 12'h400, 32'h0, 4'h0, 1'b0, lat, dq, er, rn, en2, dn);
        chk("oor_no_alias", dq, 32'h0BADCAFE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
